// File: rtl/wbu_cwassemble.sv
// Packs 1, 2, 3 or 6 sextets from the ASCII-to-sextet decoder into one
// left-aligned 36-bit codeword and hands it to the command decoder.
module wbu_cwassemble (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_soft_reset,
  input  logic        i_stb,
  input  logic        i_valid,
  input  logic [5:0]  i_hexbits,
  output logic        o_busy,
  output logic        o_stb,
  output logic [35:0] o_word,
  input  logic        i_busy,
  output logic        o_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_remaining, w_remaining_nx;
  logic [2:0]  r_slot, w_slot_nx;
  logic [35:0] r_sreg, w_sreg_nx;
  logic [35:0] r_word, w_word_nx;
  logic [35:0] w_filled;
  logic [2:0]  w_len;
  logic        r_stb, w_stb_nx;
  logic        r_err, w_err_nx;
  logic        w_accept;
  logic        w_clear;

  // Header bits [5:4] select the codeword length in sextets.
  function automatic logic [2:0] f_length(input logic [5:0] hdr);
    logic [2:0] len;
    case (hdr[5:4])
      2'b00:   len = 3'd6;
      2'b01:   len = 3'd2;
      2'b10:   len = 3'd3;
      2'b11:   len = 3'd1;
      default: len = 3'd6;
    endcase
    return len;
  endfunction

  function automatic logic [35:0] f_insert(input logic [35:0] sreg,
                                           input logic [2:0]  slot,
                                           input logic [5:0]  hex);
    logic [35:0] res;
    res = sreg;
    case (slot)
      3'd0:    res[35:30] = hex;
      3'd1:    res[29:24] = hex;
      3'd2:    res[23:18] = hex;
      3'd3:    res[17:12] = hex;
      3'd4:    res[11:6]  = hex;
      3'd5:    res[5:0]   = hex;
      default: res = sreg;
    endcase
    return res;
  endfunction

  assign o_busy   = r_stb && i_busy;
  assign w_accept = i_stb && !o_busy;
  assign w_clear  = i_reset || i_soft_reset;
  assign w_len    = f_length(i_hexbits);
  assign w_filled = f_insert(r_sreg, r_slot, i_hexbits);

  // Next-state and output-register computation.
  always_comb begin
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    w_slot_nx      = r_slot;
    w_sreg_nx      = r_sreg;
    w_word_nx      = r_word;
    w_err_nx       = 1'b0;
    // A held word stays presented only while downstream stalls.
    w_stb_nx       = r_stb && i_busy;
    if (w_accept && i_valid) begin
      if (r_state == S_IDLE) begin
        w_sreg_nx = {i_hexbits, 30'd0};
        if (w_len == 3'd1) begin
          w_stb_nx       = 1'b1;
          w_word_nx      = {i_hexbits, 30'd0};
          w_remaining_nx = 3'd0;
          w_slot_nx      = 3'd0;
        end else begin
          w_state_nx     = S_FILL;
          w_remaining_nx = w_len - 3'd1;
          w_slot_nx      = 3'd1;
        end
      end else begin
        w_sreg_nx      = w_filled;
        w_remaining_nx = r_remaining - 3'd1;
        if (r_remaining == 3'd1) begin
          w_stb_nx   = 1'b1;
          w_word_nx  = w_filled;
          w_state_nx = S_IDLE;
          w_slot_nx  = 3'd0;
        end else begin
          w_slot_nx  = r_slot + 3'd1;
        end
      end
    end else if (w_accept && (r_state == S_FILL)) begin
      // Non-code character mid-word abandons the partial codeword.
      w_err_nx       = 1'b1;
      w_state_nx     = S_IDLE;
      w_remaining_nx = 3'd0;
      w_slot_nx      = 3'd0;
      w_sreg_nx      = 36'd0;
    end else begin
      w_err_nx = 1'b0;
    end
  end

  // State and output registers; either reset wins over a same-cycle accept.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state     <= S_IDLE;
      r_remaining <= 3'd0;
      r_slot      <= 3'd0;
      r_sreg      <= 36'd0;
      r_word      <= 36'd0;
      r_stb       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_remaining <= w_remaining_nx;
      r_slot      <= w_slot_nx;
      r_sreg      <= w_sreg_nx;
      r_word      <= w_word_nx;
      r_stb       <= w_stb_nx;
      r_err       <= w_err_nx;
    end
  end

  assign o_stb  = r_stb;
  assign o_word = r_word;
  assign o_err  = r_err;

endmodule
